// File: rtl/demux2_stream_if.sv
// Stream bundle for demux2_stream: one input stream (d/d_valid/d_ready/sel)
// and two output channels (z0, z1), each with a valid/ready handshake.
// master: the environment side (producer and both consumers).
// slave:  the demultiplexer itself.
interface demux2_stream_if #(
    parameter int unsigned W = 1
) ();
    logic [W-1:0] d;
    logic         d_valid;
    logic         d_ready;
    logic         sel;
    logic [W-1:0] z0;
    logic         z0_valid;
    logic         z0_ready;
    logic [W-1:0] z1;
    logic         z1_valid;
    logic         z1_ready;

    modport master (
        output d, d_valid, sel, z0_ready, z1_ready,
        input  d_ready, z0, z0_valid, z1, z1_valid
    );

    modport slave (
        input  d, d_valid, sel, z0_ready, z1_ready,
        output d_ready, z0, z0_valid, z1, z1_valid
    );
endinterface

// File: rtl/demux2_stream.sv
// demux2_stream: 1-to-2 registered stream demultiplexer.
// The input word is steered by sel into one of two one-entry holding
// registers, each with its own valid/ready handshake. A channel can drain
// and reload in the same cycle, so a ready consumer sees no bubbles.
// Optional feature: define DEMUX2_CNT_EN to add per-channel accept counters
// cnt0/cnt1 (CW bits, wrapping).
module demux2_stream #(
    parameter int unsigned W  = 1,
    parameter int unsigned CW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    demux2_stream_if.slave      bus
`ifdef DEMUX2_CNT_EN
    ,
    output logic [CW-1:0]       cnt0,
    output logic [CW-1:0]       cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    // Reject degenerate widths at elaboration.
    if (W < 1 || CW < 1) begin : g_bad_width
        $error("demux2_stream: W and CW must be at least 1");
    end

    ch_state_t    state0;
    ch_state_t    state1;
    logic [W-1:0] hold0;
    logic [W-1:0] hold1;
    logic [W-1:0] d_word;
    logic         ch_free;
    logic         accept;
    logic         load0;
    logic         load1;
    logic         drain0;
    logic         drain1;

    assign d_word = bus.d;

    // Selected channel can take a word if empty or draining this cycle.
    always_comb begin
        ch_free = 1'b0;
        if (bus.sel) begin
            ch_free = (state1 == EMPTY) || bus.z1_ready;
        end else begin
            ch_free = (state0 == EMPTY) || bus.z0_ready;
        end
    end

    assign accept = bus.d_valid && ch_free;
    assign load0  = accept && !bus.sel;
    assign load1  = accept && bus.sel;
    assign drain0 = (state0 == FULL) && bus.z0_ready;
    assign drain1 = (state1 == FULL) && bus.z1_ready;

    // Channel 0 holding register: load wins over drain (no bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0 <= EMPTY;
            hold0  <= '0;
        end else if (load0) begin
            state0 <= FULL;
            hold0  <= d_word;
        end else if (drain0) begin
            state0 <= EMPTY;
        end
    end

    // Channel 1 holding register: load wins over drain (no bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1 <= EMPTY;
            hold1  <= '0;
        end else if (load1) begin
            state1 <= FULL;
            hold1  <= d_word;
        end else if (drain1) begin
            state1 <= EMPTY;
        end
    end

    assign bus.d_ready  = ch_free;
    assign bus.z0       = hold0;
    assign bus.z1       = hold1;
    assign bus.z0_valid = (state0 == FULL);
    assign bus.z1_valid = (state1 == FULL);

`ifdef DEMUX2_CNT_EN
    // Per-channel accept counters, wrapping at 2^CW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (load0) begin
                cnt0 <= cnt0 + CW'(1);
            end
            if (load1) begin
                cnt1 <= cnt1 + CW'(1);
            end
        end
    end
`endif

endmodule
